// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or
// restoring shift-subtract step per cycle, sign fix-up in a final state.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Input_A,
  input  logic [WIDTH-1:0] Input_B,
  input  logic [2:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb;
  logic                 is_div, sign_a, sign_b, b_zero;

  logic                 accept, op_signed;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   mul_nxt, div_nxt, prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Operand decode: signed ops work on magnitudes, signs kept aside
  always_comb begin
    op_signed = (op == 3'd0) || (op == 3'd2);
    accept    = (state == IDLE) && start && (op[2] == 1'b0);
    a_mag     = (op_signed && Input_A[WIDTH-1]) ? -Input_A : Input_A;
    b_mag     = (op_signed && Input_B[WIDTH-1]) ? -Input_B : Input_B;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb})
                       : {1'b0, acc[2*WIDTH-1:WIDTH]};
    mul_nxt   = {mul_sum, acc[WIDTH-1:1]};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opb};
    div_nxt   = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign fix-up; a zero divisor forces an all-ones quotient
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    if (b_zero) quo_fix = '1;
    rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == LAST_ITER) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            acc    <= {WIDTH'(0), a_mag};
            opb    <= b_mag;
            is_div <= op[1];
            sign_a <= op_signed & Input_A[WIDTH-1];
            sign_b <= op_signed & Input_B[WIDTH-1];
            b_zero <= (Input_B == '0);
            cnt    <= '0;
          end else if (start && op == 3'd4) begin
            hi <= Input_A;
          end else if (start && op == 3'd5) begin
            lo <= Input_A;
          end
        end
        RUN: begin
          acc <= is_div ? div_nxt : mul_nxt;
          cnt <= cnt + CNT_W'(1);
        end
        FIN: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            lo <= prod_fix[WIDTH-1:0];
            hi <= prod_fix[2*WIDTH-1:WIDTH];
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle-level behavioural model with
// per-cycle comparison plus hand-computed literal results.
module tb_mult_div_unit;
  localparam int unsigned WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] Input_A, Input_B;
  logic [2:0]  op;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .Input_A(Input_A), .Input_B(Input_B),
    .op(op), .start(start), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sp;
    int     q, r;
    case (o)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return 64'(sp);
      end
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left = 0;
  bit          m_done = 1'b0;
  bit          chk_en = 1'b0;

  // Model: an accepted op completes WIDTH+1 edges later
  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; chk_en = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
      end
    end else if (start) begin
      if (op <= 3'd3) begin
        {p_hi, p_lo} = ref_result(op, Input_A, Input_B);
        m_left = WIDTH + 1;
      end else if (op == 3'd4) m_hi = Input_A;
      else if (op == 3'd5) m_lo = Input_A;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 32'(busy), 32'(m_left != 0));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
    end
  end

  // Issue an op, scramble operands after acceptance, count edges to done
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    op = o; Input_A = a; Input_B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; Input_A = $urandom; Input_B = $urandom;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic lit(input string name, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo);
    int lat;
    run_op(o, a, b, lat);
    check({name, "_lat"}, 32'(lat), 32'd33);
    check({name, "_hi"}, hi, e_hi);
    check({name, "_lo"}, lo, e_lo);
  endtask

  logic [2:0]  t_op [7] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd3, 3'd2, 3'd1};
  logic [31:0] t_a  [7] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FF9C, 32'd100,
                            32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'd0};
  logic [31:0] t_b  [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'd1, 32'd0, 32'h1234};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, dcount;
    logic [63:0] e;
    reset = 1'b1; start = 1'b0; op = 3'd7; Input_A = '0; Input_B = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    lit("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    lit("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    lit("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    lit("divu_small", 3'd3, 32'd1111, 32'd9999, 32'd1111, 32'd0);
    lit("divu_zero", 3'd3, 32'd9999, 32'd0, 32'd9999, 32'hFFFF_FFFF);
    lit("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    lit("div_zero_s", 3'd2, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF);

    for (int i = 0; i < 7; i++) begin
      e = ref_result(t_op[i], t_a[i], t_b[i]);
      run_op(t_op[i], t_a[i], t_b[i], lat);
      check("tbl_lat", 32'(lat), 32'd33);
      check("tbl_hi", hi, e[63:32]);
      check("tbl_lo", lo, e[31:0]);
    end

    // Start while busy must be dropped
    op = 3'd0; Input_A = 32'd5; Input_B = 32'd6; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 op = 3'd3; Input_A = 32'd100; Input_B = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 5;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    check("busy_start_lat", 32'(lat), 32'd33);
    check("busy_start_hi", hi, 32'd0);
    check("busy_start_lo", lo, 32'd30);

    // Back-to-back: start issued while done is high
    lit("b2b", 3'd1, 32'd12, 32'd13, 32'd0, 32'd156);

    // Ops 6 and 7 ignored
    op = 3'd6; Input_A = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1 op = 3'd7;
    @(posedge clk); #1 start = 1'b0;
    check("nop_busy", 32'(busy), 32'd0);
    check("nop_lo", lo, 32'd156);

    // Reset during a divide aborts with no write
    op = 3'd2; Input_A = 32'hFFFF_FFF9; Input_B = 32'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);

    op = 3'd4; Input_A = 32'h1234; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_busy", 32'(busy), 32'd0);
    op = 3'd5; Input_A = 32'h5678; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi", hi, 32'h1234);
    check("mtlo_done", 32'(done), 32'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
